// File: rtl/pll_reconf_sequencer.sv
// ============================================================================
//  Module      : pll_reconf_sequencer
//  Description : Upstream sequencer for the PLL scan-chain reconfiguration
//                wrapper. Accepts a PLL setting (M, N, C0..C4) over a
//                valid/ready handshake and rejects it if any field is zero.
//                It then holds the setting on the wrapper's config inputs and
//                pulses update_req. After that it waits for a scan-done rising
//                edge and for a stable synchronised PLL lock. The result is
//                reported as a one-cycle done pulse, or as an err pulse with a
//                2-bit err_code.
//  Ports       : clock_i / rst_i              clock, async active-high reset
//                req_*_i / req_ready_o        host request handshake + fields
//                mult_o, div_o, clkN_div_o    held settings to config wrapper
//                update_req_o                 one-cycle start pulse to wrapper
//                from_pll_scan_done_i         scan complete (clock_i domain)
//                pll_locked_i                 PLL lock (asynchronous)
//                busy_o, done_o, err_o        host status
//                err_code_o                   0 none, 1 bad param,
//                                             2 scan timeout, 3 lock timeout
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pll_reconf_sequencer #(
    parameter int SCAN_TIMEOUT = 4096,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 16,
    parameter int MAX_RETRY    = 2,
    parameter int CNT_W        = 17
) (
    input  logic        clock_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [7:0]  req_mult_i,
    input  logic [7:0]  req_div_i,
    input  logic [39:0] req_cdiv_i,
    output logic [7:0]  mult_o,
    output logic [7:0]  div_o,
    output logic [7:0]  clk0_div_o,
    output logic [7:0]  clk1_div_o,
    output logic [7:0]  clk2_div_o,
    output logic [7:0]  clk3_div_o,
    output logic [7:0]  clk4_div_o,
    output logic        update_req_o,
    input  logic        from_pll_scan_done_i,
    input  logic        pll_locked_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    localparam int STB_W = $clog2(LOCK_STABLE + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0] c_SCAN_LAST   = CNT_W'(SCAN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [STB_W-1:0] c_LOCK_STABLE = STB_W'(LOCK_STABLE);
    localparam logic [STB_W-1:0] c_STB_ONE     = STB_W'(1);
    localparam logic [STB_W-1:0] c_STB_MAX     = {STB_W{1'b1}};
    localparam logic [RTY_W-1:0] c_MAX_RETRY   = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0] c_RTY_ONE     = RTY_W'(1);

    localparam logic [1:0] c_ERR_NONE  = 2'd0;
    localparam logic [1:0] c_ERR_PARAM = 2'd1;
    localparam logic [1:0] c_ERR_SCAN  = 2'd2;
    localparam logic [1:0] c_ERR_LOCK  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_REQ       = 3'd2,
        S_WAIT_SCAN = 3'd3,
        S_WAIT_LOCK = 3'd4,
        S_DONE      = 3'd5,
        S_ERR       = 3'd6
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [STB_W-1:0]  stable_q;
    logic [STB_W-1:0]  stable_d;
    logic [RTY_W-1:0]  retry_q;
    logic              lock_meta_q;
    logic              lock_sync_q;
    logic              scan_prev_q;

    logic [7:0]        mult_q;
    logic [7:0]        div_q;
    logic [39:0]       cdiv_q;
    logic              req_ready_q;
    logic              update_req_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [1:0]        err_code_q;

    logic              w_scan_rise;
    logic              w_fields_ok;

    // Edge, not level: a scan-done left high from an earlier scan must not
    // complete the current one.
    assign w_scan_rise = from_pll_scan_done_i & ~scan_prev_q;

    assign w_fields_ok = (|mult_q) & (|div_q) &
                         (|cdiv_q[7:0])   & (|cdiv_q[15:8])  & (|cdiv_q[23:16]) &
                         (|cdiv_q[31:24]) & (|cdiv_q[39:32]);

    // Consecutive-lock run length, saturating; any unlocked cycle restarts it.
    always_comb begin
        stable_d = stable_q;
        if (!lock_sync_q) begin
            stable_d = '0;
        end else if (stable_q != c_STB_MAX) begin
            stable_d = stable_q + c_STB_ONE;
        end
    end

    always_ff @(posedge clock_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            stable_q     <= '0;
            retry_q      <= '0;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
            scan_prev_q  <= 1'b0;
            mult_q       <= '0;
            div_q        <= '0;
            cdiv_q       <= '0;
            req_ready_q  <= 1'b1;
            update_req_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= c_ERR_NONE;
        end else begin
            lock_meta_q  <= pll_locked_i;
            lock_sync_q  <= lock_meta_q;
            scan_prev_q  <= from_pll_scan_done_i;

            // Pulse outputs default low; only the transitions below raise them.
            update_req_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        mult_q      <= req_mult_i;
                        div_q       <= req_div_i;
                        cdiv_q      <= req_cdiv_i;
                        err_code_q  <= c_ERR_NONE;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (!w_fields_ok) begin
                        err_code_q <= c_ERR_PARAM;
                        err_q      <= 1'b1;
                        state_q    <= S_ERR;
                    end else begin
                        update_req_q <= 1'b1;
                        state_q      <= S_REQ;
                    end
                end

                S_REQ: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT_SCAN;
                end

                S_WAIT_SCAN: begin
                    // The edge test comes first so it beats a coincident timeout.
                    if (w_scan_rise) begin
                        cnt_q    <= '0;
                        stable_q <= '0;
                        state_q  <= S_WAIT_LOCK;
                    end else if (cnt_q == c_SCAN_LAST) begin
                        err_code_q <= c_ERR_SCAN;
                        err_q      <= 1'b1;
                        state_q    <= S_ERR;
                    end else if (cnt_q != c_CNT_MAX) begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end

                S_WAIT_LOCK: begin
                    stable_q <= stable_d;
                    // The stable test comes first so lock beats a coincident timeout.
                    if (stable_d == c_LOCK_STABLE) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (cnt_q == c_LOCK_LAST) begin
                        if (retry_q < c_MAX_RETRY) begin
                            retry_q      <= retry_q + c_RTY_ONE;
                            update_req_q <= 1'b1;
                            state_q      <= S_REQ;
                        end else begin
                            err_code_q <= c_ERR_LOCK;
                            err_q      <= 1'b1;
                            state_q    <= S_ERR;
                        end
                    end else if (cnt_q != c_CNT_MAX) begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end

                S_DONE, S_ERR: begin
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    retry_q     <= '0;
                    state_q     <= S_IDLE;
                end

                default: begin
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    retry_q     <= '0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign mult_o       = mult_q;
    assign div_o        = div_q;
    assign clk0_div_o   = cdiv_q[7:0];
    assign clk1_div_o   = cdiv_q[15:8];
    assign clk2_div_o   = cdiv_q[23:16];
    assign clk3_div_o   = cdiv_q[31:24];
    assign clk4_div_o   = cdiv_q[39:32];
    assign update_req_o = update_req_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign err_code_o   = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_reconf_sequencer.sv
// ============================================================================
//  Module      : tb_pll_reconf_sequencer
//  Description : Self-checking bench for pll_reconf_sequencer. The bench uses
//                a fixed vector table and hand-written reset and handshake
//                sequences. It also runs randomized requests and checks them
//                against a timing model derived from the sequencing rules.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pll_reconf_sequencer;

    localparam int S  = 64;    // scan timeout
    localparam int LT = 200;   // lock timeout
    localparam int LS = 16;    // lock stable cycles
    localparam int MR = 2;     // retries

    localparam int K_NONE = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [7:0]  req_mult = '0;
    logic [7:0]  req_div = '0;
    logic [39:0] req_cdiv = '0;
    logic        scan_done;
    logic        pll_locked;
    logic        req_ready_o, update_req_o, busy_o, done_o, err_o;
    logic [7:0]  mult_o, div_o, clk0_o, clk1_o, clk2_o, clk3_o, clk4_o;
    logic [1:0]  err_code_o;

    always #5 clk = ~clk;

    pll_reconf_sequencer #(
        .SCAN_TIMEOUT(S), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS),
        .MAX_RETRY(MR), .CNT_W(17)
    ) dut (
        .clock_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_mult_i(req_mult), .req_div_i(req_div), .req_cdiv_i(req_cdiv),
        .mult_o(mult_o), .div_o(div_o),
        .clk0_div_o(clk0_o), .clk1_div_o(clk1_o), .clk2_div_o(clk2_o),
        .clk3_div_o(clk3_o), .clk4_div_o(clk4_o),
        .update_req_o(update_req_o),
        .from_pll_scan_done_i(scan_done), .pll_locked_i(pll_locked),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    // Cycle counter and event monitor (sampled on the falling edge).
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int upd_cnt = 0, acc_cnt = 0, acc_cyc = 0, ev_cnt = 0, ev_cyc = 0, ev_kind = 0, ev_code = 0;
    always @(negedge clk) begin
        if (update_req_o === 1'b1) upd_cnt++;
        if (req_valid && req_ready_o === 1'b1) begin acc_cnt++; acc_cyc = cyc; end
        if (done_o === 1'b1 || err_o === 1'b1) begin
            ev_cnt++;
            ev_cyc  = cyc;
            ev_kind = (done_o === 1'b1 && err_o === 1'b1) ? 3 : (done_o === 1'b1 ? K_DONE : K_ERR);
            ev_code = int'(err_code_o);
        end
    end

    // PLL-side environment: scan_mode 0 = raise scan-done scan_dly cycles after
    // each update_req, 1 = hold scan-done high. lock_mode 0 = locked,
    // 1 = unlocked, 2 = low one cycle in every ten.
    int scan_mode = 0, scan_dly = 1, lock_mode = 0;
    initial begin
        int dn, tog;
        dn = 0; tog = 0;
        scan_done = 1'b0; pll_locked = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (lock_mode)
                0:       pll_locked = 1'b1;
                1:       pll_locked = 1'b0;
                default: begin pll_locked = (tog != 9); tog = (tog == 9) ? 0 : tog + 1; end
            endcase
            if (scan_mode == 1) begin
                scan_done = 1'b1; dn = 0;
            end else if (update_req_o === 1'b1) begin
                scan_done = 1'b0; dn = scan_dly;
            end else if (dn > 0) begin
                dn--;
                if (dn == 0) scan_done = 1'b1;
            end
        end
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // One request/response. lat = cycles from the accept cycle to the done/err pulse.
    task automatic run_txn(input logic [7:0] m, input logic [7:0] n, input logic [39:0] c,
                           input int smode, input int d, input int lmode,
                           output int kind, output int code, output int lat, output int nupd);
        int b_upd, b_ev, a, k;
        scan_mode = smode; scan_dly = d; lock_mode = lmode;
        tick(25);
        b_upd = upd_cnt; b_ev = ev_cnt;
        req_mult = m; req_div = n; req_cdiv = c; req_valid = 1'b1; a = cyc;
        tick(1);
        req_valid = 1'b0;
        k = 0;
        while (ev_cnt == b_ev && k < 3000) begin tick(1); k++; end
        if (ev_cnt == b_ev) begin
            kind = K_NONE; code = 0; lat = -1;
        end else begin
            kind = ev_kind; code = ev_code; lat = ev_cyc - a;
        end
        nupd = upd_cnt - b_upd;
    endtask

    // Reference outcome computed from the sequencing rules:
    //  CHECK takes one cycle after accept and update_req follows one cycle later.
    //  Scan-done must rise within S cycles of update_req.
    //  Lock completes once the run of synchronised-locked cycles reaches LS.
    //  Each lock-wait attempt lasts LT cycles before a retry or the error.
    function automatic void model(input logic [7:0] m, input logic [7:0] n, input logic [39:0] c,
                                  input int d, input int lmode,
                                  output int kind, output int code, output int upd, output int lat);
        bit zero;
        zero = (m == 0) || (n == 0);
        for (int i = 0; i < 5; i++) if (c[i*8 +: 8] == 8'd0) zero = 1'b1;
        if (zero) begin
            kind = K_ERR; code = 1; upd = 0; lat = 2;
        end else if (d > S) begin
            kind = K_ERR; code = 2; upd = 1; lat = 2 + S + 1;
        end else if (lmode == 0) begin
            kind = K_DONE; code = 0; upd = 1; lat = 2 + d + LS + 1;
        end else begin
            kind = K_ERR; code = 3; upd = MR + 1; lat = 2 + (MR + 1) * (d + LT + 1);
        end
    endfunction

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  n;
        logic [39:0] c;
        int smode, d, lmode;
        int kind, code, upd, lat;
    } vec_t;

    task automatic check_txn(input string tag, input logic [7:0] m, input logic [7:0] n,
                             input logic [39:0] c, input int kind, input int code, input int lat,
                             input int nupd, input int e_kind, input int e_code, input int e_upd,
                             input int e_lat);
        chk({tag, " kind"}, kind, e_kind);
        chk({tag, " err_code"}, code, e_code);
        chk({tag, " update_req pulses"}, nupd, e_upd);
        chk({tag, " latency"}, lat, e_lat);
        chk({tag, " err_code held"}, err_code_o, e_code);
        chk({tag, " req_ready after"}, req_ready_o, 1);
        chk({tag, " busy after"}, busy_o, 0);
        if (e_kind == K_DONE)
            chk({tag, " held settings"}, {clk4_o, clk3_o, clk2_o, clk1_o, clk0_o, div_o, mult_o},
                {c, n, m});
    endtask

    initial begin
        vec_t tbl[8];
        int kind, code, lat, nupd;
        int ek, ec, eu, el;
        int b_ev, b_acc, a, k;
        logic [7:0]  m, n;
        logic [39:0] c;

        tbl[0] = '{8'd8,   8'd1,   40'h04_0404_0404, 0, 50, 0, K_DONE, 0, 1, 69};
        tbl[1] = '{8'd8,   8'd0,   40'h04_0404_0404, 0, 50, 0, K_ERR,  1, 0, 2};
        tbl[2] = '{8'd8,   8'd1,   40'h00_0404_0404, 0, 50, 0, K_ERR,  1, 0, 2};
        tbl[3] = '{8'd8,   8'd1,   40'h04_0404_0404, 0, 64, 0, K_DONE, 0, 1, 83};
        tbl[4] = '{8'd8,   8'd1,   40'h04_0404_0404, 0, 65, 0, K_ERR,  2, 1, 67};
        tbl[5] = '{8'd8,   8'd1,   40'h04_0404_0404, 1,  0, 0, K_ERR,  2, 1, 67};
        tbl[6] = '{8'd8,   8'd1,   40'h04_0404_0404, 0,  5, 2, K_ERR,  3, 3, 620};
        tbl[7] = '{8'd255, 8'd255, 40'hFF_FFFF_FFFF, 0,  1, 0, K_DONE, 0, 1, 20};

        // Reset state.
        tick(3);
        chk("reset req_ready", req_ready_o, 1);
        chk("reset busy", busy_o, 0);
        chk("reset update_req", update_req_o, 0);
        chk("reset done/err", {done_o, err_o}, 0);
        chk("reset err_code", err_code_o, 0);
        chk("reset settings", {clk4_o, clk3_o, clk2_o, clk1_o, clk0_o, div_o, mult_o}, 0);
        rst = 1'b0;
        tick(2);

        // Table-driven vectors.
        foreach (tbl[i]) begin
            run_txn(tbl[i].m, tbl[i].n, tbl[i].c, tbl[i].smode, tbl[i].d, tbl[i].lmode,
                    kind, code, lat, nupd);
            check_txn($sformatf("vec%0d", i), tbl[i].m, tbl[i].n, tbl[i].c, kind, code, lat, nupd,
                      tbl[i].kind, tbl[i].code, tbl[i].upd, tbl[i].lat);
        end

        // Reset asserted while waiting for lock.
        scan_mode = 0; scan_dly = 10; lock_mode = 0;
        tick(25);
        req_mult = 8'd3; req_div = 8'd2; req_cdiv = 40'h05_0607_0809; req_valid = 1'b1;
        tick(1);
        req_valid = 1'b0;
        tick(14);
        chk("rst-mid busy before", busy_o, 1);
        rst = 1'b1;
        #1;
        chk("rst-mid update_req", update_req_o, 0);
        chk("rst-mid busy", busy_o, 0);
        chk("rst-mid done/err", {done_o, err_o}, 0);
        chk("rst-mid req_ready", req_ready_o, 1);
        chk("rst-mid settings cleared", mult_o, 0);
        tick(2);
        rst = 1'b0;
        b_ev = ev_cnt;
        tick(40);
        chk("rst-mid no stale result", ev_cnt - b_ev, 0);
        run_txn(8'd3, 8'd2, 40'h05_0607_0809, 0, 20, 0, kind, code, lat, nupd);
        check_txn("after-rst", 8'd3, 8'd2, 40'h05_0607_0809, kind, code, lat, nupd,
                  K_DONE, 0, 1, 2 + 20 + LS + 1);

        // req_valid held through a whole operation.
        scan_mode = 0; scan_dly = 30; lock_mode = 0;
        tick(25);
        b_ev = ev_cnt; b_acc = acc_cnt;
        req_mult = 8'd8; req_div = 8'd1; req_cdiv = 40'h04_0404_0404; req_valid = 1'b1; a = cyc;
        k = 0;
        while (ev_cnt == b_ev && k < 3000) begin tick(1); k++; end
        chk("held-valid first result done", ev_kind, K_DONE);
        chk("held-valid first latency", ev_cyc - a, 2 + 30 + LS + 1);
        chk("held-valid single accept", acc_cnt - b_acc, 1);
        tick(1);
        chk("held-valid second accept", acc_cnt - b_acc, 2);
        chk("held-valid second accept cycle", acc_cyc - ev_cyc, 1);
        req_valid = 1'b0;
        b_ev = ev_cnt;
        k = 0;
        while (ev_cnt == b_ev && k < 3000) begin tick(1); k++; end
        chk("held-valid second result done", ev_kind, K_DONE);

        // Randomized requests against the reference model.
        for (int it = 0; it < 12; it++) begin
            m = 8'($urandom_range(1, 255));
            n = 8'($urandom_range(1, 255));
            for (int f = 0; f < 5; f++) c[f*8 +: 8] = 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, 6);
                if (k == 0)      m = 8'd0;
                else if (k == 1) n = 8'd0;
                else             c[(k-2)*8 +: 8] = 8'd0;
            end
            a = $urandom_range(1, S + 6);
            k = ($urandom_range(0, 4) == 0) ? 1 : 0;
            model(m, n, c, a, k, ek, ec, eu, el);
            run_txn(m, n, c, 0, a, k, kind, code, lat, nupd);
            check_txn($sformatf("rand%0d", it), m, n, c, kind, code, lat, nupd, ek, ec, eu, el);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

`default_nettype wire
